uart_rx_sampler: RTL and testbench

Serial receive front end fed by the baud rate generator's oversampled receive strobe. Synchronises the asynchronous RX line and detects start bits. Majority-votes three mid-bit samples per bit and assembles LSB-first frames: start, DataWidth data bits, one stop bit. Presents each byte on a valid/ready interface to the UART register block, with framing-error and overrun status.

---
 rtl/uart_rx_sampler.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises the RX line, votes three mid-bit samples per bit,
// assembles LSB-first frames and hands bytes out on valid/ready with framing/overrun status.
module uart_rx_sampler #(
    parameter int DataWidth  = 8,
    parameter int Oversample = 16,
    parameter int SyncStages = 2
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 syncReset,
    input  logic                 rxTick,
    input  logic                 rxIn,
    output logic [DataWidth-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 framingError,
    output logic                 overrun,
    input  logic                 clrOverrun,
    output logic                 busy
);

    localparam int TW = $clog2(Oversample);
    localparam int BW = $clog2(DataWidth + 1);
    localparam logic [TW-1:0] MID_M1    = TW'(Oversample / 2 - 1);
    localparam logic [TW-1:0] MID       = TW'(Oversample / 2);
    localparam logic [TW-1:0] MID_P1    = TW'(Oversample / 2 + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(Oversample - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DataWidth - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_nxt;
    logic [TW-1:0]          tick_cnt, tick_cnt_nxt;
    logic [BW-1:0]          bit_idx, bit_idx_nxt;
    logic [DataWidth-1:0]   shreg, shreg_nxt;
    logic [1:0]             samp, samp_nxt;
    logic [SyncStages-1:0]  sync_q;
    logic                   rx_s;
    logic                   vote;
    logic                   complete;
    logic                   accept;

    // Synchroniser resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '1;
        end else if (syncReset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], rxIn};
        end
    end

    assign rx_s = sync_q[SyncStages-1];
    // Third sample is the live synchronised line on tick Mid+1.
    assign vote = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            samp     <= '0;
        end else if (syncReset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            samp     <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            samp     <= samp_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        samp_nxt     = samp;
        complete     = 1'b0;
        if (rxTick) begin
            if (tick_cnt == MID_M1) samp_nxt[0] = rx_s;
            if (tick_cnt == MID)    samp_nxt[1] = rx_s;
            tick_cnt_nxt = tick_cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    tick_cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt    = START;
                        tick_cnt_nxt = TW'(1);
                    end
                end
                START: begin
                    if (tick_cnt == MID_P1 && vote) begin
                        state_nxt    = IDLE;
                        tick_cnt_nxt = '0;
                    end else if (tick_cnt == LAST_TICK) begin
                        state_nxt    = DATA;
                        tick_cnt_nxt = '0;
                        bit_idx_nxt  = '0;
                    end
                end
                DATA: begin
                    if (tick_cnt == MID_P1) shreg_nxt = {vote, shreg[DataWidth-1:1]};
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_nxt = '0;
                        bit_idx_nxt  = bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) state_nxt = STOP;
                    end
                end
                STOP: begin
                    // Leave at stop mid so the next start edge has half a bit of slack.
                    if (tick_cnt == MID_P1) begin
                        complete     = 1'b1;
                        state_nxt    = IDLE;
                        tick_cnt_nxt = '0;
                        bit_idx_nxt  = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign accept = !valid || ready;
    assign busy   = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            data         <= '0;
            valid        <= 1'b0;
            framingError <= 1'b0;
            overrun      <= 1'b0;
        end else if (syncReset) begin
            data         <= '0;
            valid        <= 1'b0;
            framingError <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (complete && accept) begin
                data         <= shreg;
                framingError <= !vote;
                valid        <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (complete && !accept) begin
                overrun <= 1'b1;
            end else if (clrOverrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: 8N1 frames at Oversample=16 with a tick every 4 clocks.
module tb_uart_rx_sampler;

    logic       clk;
    logic       n_reset;
    logic       sync_reset;
    logic       rx_tick;
    logic       rx_in;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       framing_error;
    logic       overrun;
    logic       clr_overrun;
    logic       busy;

    uart_rx_sampler #(.DataWidth(8), .Oversample(16), .SyncStages(2)) dut (
        .clk(clk),
        .nReset(n_reset),
        .syncReset(sync_reset),
        .rxTick(rx_tick),
        .rxIn(rx_in),
        .data(data),
        .valid(valid),
        .ready(ready),
        .framingError(framing_error),
        .overrun(overrun),
        .clrOverrun(clr_overrun),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Values applied on the next step's negedge, seen by the following posedge.
    logic drv_ready = 1'b0;
    logic drv_srst  = 1'b0;
    logic drv_clr   = 1'b0;

    int   step_cnt    = 0;
    int   phase       = 0;
    int   frame_start = 0;
    int   vcnt        = 0;
    int   vstep       = 0;
    logic [7:0] mdata = '0;
    logic       mfe   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs on the negedge, then drive the next inputs.
    task automatic step(input logic line);
        @(negedge clk);
        step_cnt++;
        if (valid) begin
            vcnt++;
            if (vcnt == 1) vstep = step_cnt;
            mdata = data;
            mfe   = framing_error;
        end
        phase       = (phase + 1) % 4;
        rx_tick     = (phase == 0);
        rx_in       = line;
        ready       = drv_ready;
        sync_reset  = drv_srst;
        clr_overrun = drv_clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic clear_mon();
        vcnt  = 0;
        vstep = 0;
        mdata = '0;
        mfe   = 1'b0;
    endtask

    // Frame starts two clocks before a tick, so tick j of the frame samples line step 4*j.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit glitch,
                              input int rdy_at, input int len);
        logic [9:0] fr;
        logic       line;
        fr = {stop_bit, b, 1'b0};
        while (phase != 1) step(1'b1);
        for (int k = 0; k < len; k++) begin
            line = fr[k / 64];
            if (glitch && k == 4 * 64 + 32) line = ~line;
            if (rdy_at >= 0) drv_ready = (k == rdy_at);
            step(line);
            if (k == 0) frame_start = step_cnt;
        end
        if (rdy_at >= 0) drv_ready = 1'b0;
    endtask

    initial begin
        n_reset     = 1'b0;
        sync_reset  = 1'b0;
        rx_tick     = 1'b0;
        rx_in       = 1'b1;
        ready       = 1'b0;
        clr_overrun = 1'b0;
        idle(3);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fe", 32'(framing_error), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        n_reset = 1'b1;
        idle(10);

        // 0x55, consumer always ready
        drv_ready = 1'b1;
        idle(1);
        clear_mon();
        send_frame(8'h55, 1'b1, 1'b0, -1, 640);
        check("f55_vcnt", 32'(vcnt), 32'd1);
        check("f55_data", 32'(mdata), 32'h55);
        check("f55_fe", 32'(mfe), 32'h0);
        check("f55_latency", 32'(vstep - frame_start), 32'd615);
        check("f55_busy", 32'(busy), 32'h0);

        // false start: line low for three ticks only
        clear_mon();
        while (phase != 1) step(1'b1);
        for (int k = 0; k < 64; k++) begin
            step((k < 12) ? 1'b0 : 1'b1);
            if (k == 20) check("glitch_busy_mid", 32'(busy), 32'h1);
            if (k == 38) check("glitch_busy_pre", 32'(busy), 32'h1);
            if (k == 39) check("glitch_busy_post", 32'(busy), 32'h0);
        end
        check("glitch_novalid", 32'(vcnt), 32'd0);

        // 0xA3 with a zero stop bit
        clear_mon();
        send_frame(8'hA3, 1'b0, 1'b0, -1, 640);
        idle(100);
        check("fa3_vcnt", 32'(vcnt), 32'd1);
        check("fa3_data", 32'(mdata), 32'hA3);
        check("fa3_fe", 32'(mfe), 32'h1);
        check("fa3_ovr", 32'(overrun), 32'h0);

        // overrun: consumer stalled across two frames
        drv_ready = 1'b0;
        idle(2);
        send_frame(8'h12, 1'b1, 1'b0, -1, 640);
        check("ovr_first_ovr", 32'(overrun), 32'h0);
        send_frame(8'h34, 1'b1, 1'b0, -1, 640);
        check("ovr_data", 32'(data), 32'h12);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_set", 32'(overrun), 32'h1);
        check("ovr_fe", 32'(framing_error), 32'h0);
        drv_ready = 1'b1;
        step(1'b1);
        drv_ready = 1'b0;
        step(1'b1);
        check("ovr_hs_valid", 32'(valid), 32'h0);
        check("ovr_hs_data", 32'(data), 32'h12);
        check("ovr_sticky", 32'(overrun), 32'h1);
        drv_clr = 1'b1;
        step(1'b1);
        drv_clr = 1'b0;
        step(1'b1);
        check("ovr_clr", 32'(overrun), 32'h0);

        // back-to-back, ready only on the second completion; bit 3 glitched at tick Mid
        idle(20);
        send_frame(8'h0F, 1'b1, 1'b0, -1, 640);
        check("b2b_first", 32'(data), 32'h0F);
        send_frame(8'hF0, 1'b1, 1'b1, 614, 640);
        check("b2b_data", 32'(data), 32'hF0);
        check("b2b_valid", 32'(valid), 32'h1);
        check("b2b_ovr", 32'(overrun), 32'h0);

        // syncReset in the middle of DATA
        send_frame(8'h3C, 1'b1, 1'b0, -1, 200);
        check("srst_busy_pre", 32'(busy), 32'h1);
        drv_srst = 1'b1;
        step(1'b1);
        drv_srst = 1'b0;
        step(1'b1);
        check("srst_data", 32'(data), 32'h0);
        check("srst_valid", 32'(valid), 32'h0);
        check("srst_busy", 32'(busy), 32'h0);
        check("srst_ovr", 32'(overrun), 32'h0);
        idle(100);

        // nReset pulse during STOP
        send_frame(8'h5A, 1'b1, 1'b0, -1, 600);
        check("nrst_busy_pre", 32'(busy), 32'h1);
        n_reset = 1'b0;
        #1;
        check("nrst_busy", 32'(busy), 32'h0);
        check("nrst_valid", 32'(valid), 32'h0);
        check("nrst_data", 32'(data), 32'h0);
        check("nrst_fe", 32'(framing_error), 32'h0);
        step(1'b1);
        n_reset = 1'b1;
        idle(100);
        check("nrst_stay_idle", 32'(busy), 32'h0);

        // clean frame after resets
        drv_ready = 1'b1;
        idle(1);
        clear_mon();
        send_frame(8'hC9, 1'b1, 1'b0, -1, 640);
        check("fc9_vcnt", 32'(vcnt), 32'd1);
        check("fc9_data", 32'(mdata), 32'hC9);
        check("fc9_fe", 32'(mfe), 32'h0);
        check("fc9_ovr", 32'(overrun), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
